// File: rtl/tl_imem_responder_if.sv
// TileLink A/D channel bundle between the icache miss master and tl_imem_responder.
interface tl_imem_responder_if;
    logic [2:0]  slave_a_opcode;
    logic [2:0]  slave_a_param;
    logic [3:0]  slave_a_size;
    logic [31:0] slave_a_address;
    logic [3:0]  slave_a_mask;
    logic [31:0] slave_a_data;
    logic        slave_a_corrupt;
    logic        slave_a_valid;
    logic        slave_a_ready;
    logic [2:0]  slave_d_opcode;
    logic [1:0]  slave_d_param;
    logic [3:0]  slave_d_size;
    logic        slave_d_denied;
    logic [31:0] slave_d_data;
    logic        slave_d_corrupt;
    logic        slave_d_valid;
    logic        slave_d_ready;

    modport master (
        output slave_a_opcode, slave_a_param, slave_a_size, slave_a_address,
               slave_a_mask, slave_a_data, slave_a_corrupt, slave_a_valid, slave_d_ready,
        input  slave_a_ready, slave_d_opcode, slave_d_param, slave_d_size,
               slave_d_denied, slave_d_data, slave_d_corrupt, slave_d_valid
    );

    modport slave (
        input  slave_a_opcode, slave_a_param, slave_a_size, slave_a_address,
               slave_a_mask, slave_a_data, slave_a_corrupt, slave_a_valid, slave_d_ready,
        output slave_a_ready, slave_d_opcode, slave_d_param, slave_d_size,
               slave_d_denied, slave_d_data, slave_d_corrupt, slave_d_valid
    );
endinterface

// File: rtl/tl_imem_responder.sv
// TL-UH responder in front of a synchronous single-port word memory (instruction store).
// Define TL_IMEM_WRITE_EN to service PutFullData/PutPartialData; otherwise Puts are denied.
module tl_imem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          MAX_SIZE    = 6
) (
    input  logic                           cpu_clock_i,
    input  logic                           reset_ni,
    tl_imem_responder_if.slave             tl,
    output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr_o,
    output logic                           mem_re_o,
    input  logic [31:0]                    mem_rdata_i,
    output logic                           mem_we_o,
    output logic [3:0]                     mem_wmask_o,
    output logic [31:0]                    mem_wdata_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [33:0] LIMIT = {2'b00, ADDR_BASE} + 34'(DEPTH_WORDS) * 34'd4;
    localparam logic [2:0] OP_GET = 3'd4, OP_PUT_FULL = 3'd0, OP_PUT_PART = 3'd1;
    localparam logic [2:0] D_ACK_DATA = 3'd1, D_ACK = 3'd0;
`ifdef TL_IMEM_WRITE_EN
    localparam logic WRITE_EN = 1'b1;
`else
    localparam logic WRITE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} state_t;

    state_t          state;
    logic            a_ready, d_valid, d_denied, d_corrupt, deny_q;
    logic [2:0]      d_opcode;
    logic [3:0]      d_size;
    logic [AW-1:0]   idx_q;
    logic [13:0]     issue_left, resp_left, wr_left;

    function automatic logic [13:0] beats_of(input logic [3:0] size);
        if (size <= 4'd2) return 14'd1;
        return 14'd1 << (size - 4'd2);
    endfunction

    // Request decode, evaluated on the beat presented in IDLE.
    logic        a_fire, d_fire, a_is_put, a_op_ok, a_align, a_in_range, a_deny;
    logic [33:0] a_bytes, a_end;
    logic [31:0] a_off;
    logic [AW-1:0] a_idx;

    assign a_fire     = tl.slave_a_valid & a_ready;
    assign d_fire     = d_valid & tl.slave_d_ready;
    assign a_is_put   = (tl.slave_a_opcode == OP_PUT_FULL) | (tl.slave_a_opcode == OP_PUT_PART);
    assign a_op_ok    = (tl.slave_a_opcode == OP_GET) | (a_is_put & WRITE_EN);
    assign a_bytes    = 34'd1 << tl.slave_a_size;
    assign a_end      = {2'b00, tl.slave_a_address} + a_bytes;
    assign a_align    = (tl.slave_a_address & (a_bytes[31:0] - 32'd1)) == 32'd0;
    assign a_in_range = (tl.slave_a_address >= ADDR_BASE) & (a_end <= LIMIT);
    assign a_deny     = !a_op_ok | ({28'd0, tl.slave_a_size} > 32'(MAX_SIZE)) | !a_align | !a_in_range;
    assign a_off      = tl.slave_a_address - ADDR_BASE;
    assign a_idx      = a_off[AW+1:2];

    // A read is only launched when the D slot is free or draining, so the
    // memory keeps holding the data of a stalled beat.
    logic issue;
    assign issue    = (state == READ) & (issue_left != 14'd0) & (!d_valid | tl.slave_d_ready);
    assign mem_re_o = issue & !deny_q;

    logic          wr_beat, we;
    logic [AW-1:0] wr_idx;
    assign wr_beat = a_fire & (((state == IDLE) & a_is_put) | (state == WRITE));
    assign we      = wr_beat & !((state == IDLE) ? a_deny : deny_q) & !tl.slave_a_corrupt & WRITE_EN;
    assign wr_idx  = (state == IDLE) ? a_idx : idx_q;

    logic unused_bits;
`ifdef TL_IMEM_WRITE_EN
    assign mem_we_o    = we;
    assign mem_wmask_o = we ? tl.slave_a_mask : 4'h0;
    assign mem_wdata_o = we ? tl.slave_a_data : 32'h0;
    assign mem_addr_o  = mem_re_o ? idx_q : (we ? wr_idx : '0);
    assign unused_bits = ^{tl.slave_a_param, a_off[1:0], a_off[31:AW+2], a_bytes[33:32]};
`else
    assign mem_we_o    = 1'b0;
    assign mem_wmask_o = 4'h0;
    assign mem_wdata_o = 32'h0;
    assign mem_addr_o  = mem_re_o ? idx_q : '0;
    assign unused_bits = ^{tl.slave_a_param, a_off[1:0], a_off[31:AW+2], a_bytes[33:32],
                           tl.slave_a_mask, tl.slave_a_data, we, wr_idx};
`endif

    assign tl.slave_a_ready   = a_ready;
    assign tl.slave_d_valid   = d_valid;
    assign tl.slave_d_opcode  = d_opcode;
    assign tl.slave_d_param   = 2'b00;
    assign tl.slave_d_size    = d_size;
    assign tl.slave_d_denied  = d_denied;
    assign tl.slave_d_corrupt = d_corrupt;
    // Read data passes straight through; it is stable because no new read issues during a stall.
    assign tl.slave_d_data    = (d_valid & (state == READ) & !deny_q) ? mem_rdata_i : 32'h0;

    always_ff @(posedge cpu_clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state      <= IDLE;
            a_ready    <= 1'b0;
            d_valid    <= 1'b0;
            d_opcode   <= 3'd0;
            d_size     <= 4'd0;
            d_denied   <= 1'b0;
            d_corrupt  <= 1'b0;
            deny_q     <= 1'b0;
            idx_q      <= '0;
            issue_left <= 14'd0;
            resp_left  <= 14'd0;
            wr_left    <= 14'd0;
        end else begin
            case (state)
                IDLE: begin
                    a_ready <= 1'b1;
                    d_valid <= 1'b0;
                    if (a_fire) begin
                        deny_q   <= a_deny;
                        d_size   <= tl.slave_a_size;
                        d_denied <= a_deny;
                        if (a_is_put) begin
                            idx_q   <= a_idx + AW'(1);
                            wr_left <= beats_of(tl.slave_a_size) - 14'd1;
                            if (beats_of(tl.slave_a_size) == 14'd1) begin
                                state     <= ACK;
                                a_ready   <= 1'b0;
                                d_valid   <= 1'b1;
                                d_opcode  <= D_ACK;
                                d_corrupt <= 1'b0;
                            end else begin
                                state <= WRITE;
                            end
                        end else begin
                            state      <= READ;
                            a_ready    <= 1'b0;
                            idx_q      <= a_idx;
                            issue_left <= beats_of(tl.slave_a_size);
                            resp_left  <= beats_of(tl.slave_a_size);
                            d_opcode   <= D_ACK_DATA;
                            d_corrupt  <= a_deny;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        issue_left <= issue_left - 14'd1;
                        idx_q      <= idx_q + AW'(1);
                        d_valid    <= 1'b1;
                    end else if (d_fire) begin
                        d_valid <= 1'b0;
                    end
                    if (d_fire) begin
                        resp_left <= resp_left - 14'd1;
                        if (resp_left == 14'd1) begin
                            state   <= IDLE;
                            a_ready <= 1'b1;
                            d_valid <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (a_fire) begin
                        idx_q   <= idx_q + AW'(1);
                        wr_left <= wr_left - 14'd1;
                        if (wr_left == 14'd1) begin
                            state     <= ACK;
                            a_ready   <= 1'b0;
                            d_valid   <= 1'b1;
                            d_opcode  <= D_ACK;
                            d_corrupt <= 1'b0;
                        end
                    end
                end
                ACK: begin
                    if (d_fire) begin
                        state   <= IDLE;
                        a_ready <= 1'b1;
                        d_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/tl_imem_responder.md
# tl_imem_responder

TileLink Uncached Heavyweight (TL-UH) responder that serves the instruction-cache miss master from a synchronous single-port word memory. It accepts A-channel requests, checks them, and drives the memory port. For Get it streams multi-beat AccessAckData bursts on the D channel under full backpressure. It sits on the memory side of the icache A/D link and is the boot/instruction store for the frontend.

## Interface
- ADDR_BASE, 32'h00000000, byte address of memory word 0
- DEPTH_WORDS, 4096, memory depth in 32-bit words (power of two)
- MAX_SIZE, 6, largest accepted log2 transfer size (64 B = 16 beats)

Ports:
- cpu_clock_i  in  1  clock, all state on rising edge
- reset_ni  in  1  reset, asynchronous, active-low
- slave_a_opcode  in  3  A opcode: 4 Get, 0 PutFullData, 1 PutPartialData
- slave_a_param  in  3  ignored
- slave_a_size  in  4  log2 bytes of transfer
- slave_a_address  in  32  byte address
- slave_a_mask  in  4  byte lanes (Put only)
- slave_a_data  in  32  write data (Put only)
- slave_a_corrupt  in  1  Put beat corrupt flag
- slave_a_valid  in  1  A beat valid
- slave_a_ready  out  1  A beat accepted
- slave_d_opcode  out  3  1 AccessAckData, 0 AccessAck
- slave_d_param  out  2  always 0
- slave_d_size  out  4  echo of request size
- slave_d_denied  out  1  request rejected
- slave_d_data  out  32  read beat
- slave_d_corrupt  out  1  beat data invalid
- slave_d_valid  out  1  D beat valid
- slave_d_ready  in  1  D beat consumed
- mem_addr_o  out  $clog2(DEPTH_WORDS)  word index
- mem_re_o  out  1  read strobe; mem_rdata_i is valid the next cycle and holds until the next strobe
- mem_rdata_i  in  32  read data
- mem_we_o  out  1  write strobe
- mem_wmask_o  out  4  byte write enables
- mem_wdata_o  out  32  write data

## Operation
- States: IDLE, READ, WRITE, ACK.
- IDLE:
  - slave_a_ready=1.
  - On A fire, latch opcode, size, address and beats = max(1, 2^size/4).
  - Compute deny = unsupported opcode | size>MAX_SIZE | address not aligned to 2^size | burst not wholly inside [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS).
  - For size<2, the whole aligned word is read or written.
- Get → READ:
  - Issue read n when beats remain to issue and (!slave_d_valid | slave_d_ready).
  - mem_addr_o = latched word index + n; the index increments per issued read and never wraps, because the burst is aligned.
  - The next cycle, slave_d_valid=1, slave_d_data=mem_rdata_i, opcode 1.
  - Leave READ for IDLE on the fire of the last beat.
  - Denied Get: no mem_re_o; emit `beats` beats with denied=1, corrupt=1, data 0.
- Put → WRITE:
  - slave_a_ready=1; each accepted beat with !deny & !slave_a_corrupt drives mem_we_o with the sequential address, mask and data.
  - After the last beat, go to ACK.
- ACK:
  - One beat, opcode 0, denied=deny, corrupt=0.
  - Return to IDLE on fire.
- slave_a_ready=0 in READ and ACK; one outstanding request only.
- D outputs stay stable while valid & !ready.

## Timing
- Reset asserted:
  - state=IDLE.
  - All outputs 0, including slave_a_ready, slave_d_valid, mem_re_o and mem_we_o.
- First rising edge after deassert: slave_a_ready=1.
- Get latency:
  - A fire at cycle 0.
  - mem_re_o at cycle 1.
  - First D beat valid at cycle 2.
- With slave_d_ready held high, one beat per cycle; a 16-beat Get completes at cycle 17.
- Backpressure: no read is issued while a valid beat is stalled; mem_rdata_i is therefore held by the memory.
- Next A accept: the cycle after the last D fire, when back in IDLE.
- Put: mem_we_o is asserted in the same cycle as its A beat fire; AccessAck is valid the cycle after the last A beat.
- Reset mid-burst: outputs drop asynchronously; the burst is abandoned.

## Configuration
- TL_IMEM_WRITE_EN defined:
  - PutFullData and PutPartialData are serviced as above.
- Not defined:
  - mem_we_o, mem_wmask_o and mem_wdata_o are tied 0.
  - Put opcodes are always denied: all beats are absorbed, then AccessAck with denied=1.
  - Get behaviour is unchanged.

## Test plan
- Get, size 6, address ADDR_BASE+0x40, memory word k = 0x1000+k, d_ready=1 → 16 beats 0x1010..0x101F on cycles 2..17, opcode 1, d_size 6, denied 0.
- Same Get with d_ready toggling 1,0,0,1,… → identical data order; no mem_re_o while a stalled beat is present; d_data stable while stalled.
- Get, size 4, address ADDR_BASE+0x8 (misaligned) → 4 beats, denied=1, corrupt=1, mem_re_o never asserted.
- Get, size 2, address ADDR_BASE+4*DEPTH_WORDS → 1 denied beat; opcode 7 at a valid address → denied response.
- PutFullData, size 3, data 0xAAAA5555 and 0x12345678 at ADDR_BASE → with the macro, two writes at words 0 and 1 with mask 0xF, then AccessAck denied=0; without the macro, no writes and denied=1.
- Assert reset_ni low at beat 5 of a 16-beat Get → d_valid=0 immediately; after release, a_ready=1 and a new Get returns correct data.
